// File: rtl/johnson_phase_decoder_if.sv
// +----------------------------------------------------------------------+
// | johnson_phase_decoder_if : count sample in, phase/health status out  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface johnson_phase_decoder_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  localparam int IDX_W = $clog2(2 * WIDTH);

  logic [WIDTH-1:0]     count_in;
  logic                 in_valid;
  logic                 err_clr;
  logic [IDX_W-1:0]     phase_idx;
  logic [2*WIDTH-1:0]   phase_onehot;
  logic                 wrap_pulse;
  logic                 code_err;
  logic                 seq_err;
  logic                 locked;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output count_in, in_valid, err_clr,
    input  phase_idx, phase_onehot, wrap_pulse, code_err, seq_err, locked, err_count
  );

  modport slave (
    input  count_in, in_valid, err_clr,
    output phase_idx, phase_onehot, wrap_pulse, code_err, seq_err, locked, err_count
  );
endinterface

`default_nettype wire

// File: rtl/johnson_phase_decoder.sv
// +----------------------------------------------------------------------+
// | johnson_phase_decoder : decodes a Johnson ring sample into a phase   |
// | index/one-hot and tracks sequence health.        Revision 1.0        |
// +----------------------------------------------------------------------+
`default_nettype none

module johnson_phase_decoder #(
  parameter int WIDTH      = 4,
  parameter int SHIFT_LEFT = 1,
  parameter int LOCK_LEN   = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  johnson_phase_decoder_if.slave  bus
);

  localparam int N     = 2 * WIDTH;
  localparam int IDX_W = $clog2(N);
  localparam int RUN_W = $clog2(LOCK_LEN + 1);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [WIDTH-1:0]     w_ori;
  logic [WIDTH-1:0]     w_tail;
  logic                 w_legal;
  logic [IDX_W-1:0]     w_ones;
  logic [IDX_W-1:0]     w_idx;
  logic [WIDTH-1:0]     w_next;
  logic                 w_in_seq;
  logic [RUN_W-1:0]     w_run_inc;
  logic                 w_err;

  logic [WIDTH-1:0]     r_prev_code;
  logic                 r_prev_ok;
  logic [RUN_W-1:0]     r_run;
  logic [0:0]           r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [N-1:0]         r_onehot;
  logic                 r_wrap;
  logic                 r_code_err;
  logic                 r_seq_err;
  logic [ERR_CNT_W-1:0] r_err_count;

  // Orient the code so the anchor bit is always the MSB; the tail (ones
  // after inverting a set anchor) must then be a solid run of low ones.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_ori[i] = (SHIFT_LEFT != 0) ? bus.count_in[i] : bus.count_in[WIDTH-1-i];
    end
    w_tail  = w_ori[WIDTH-1] ? ~w_ori : w_ori;
    w_legal = ((w_tail & (w_tail + WIDTH'(1))) == '0);
    w_ones  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ones = w_ones + IDX_W'(w_tail[i]);
    end
    w_idx = (w_ori[WIDTH-1] ? IDX_W'(WIDTH) : '0) + w_ones;
  end

  generate
    if (SHIFT_LEFT != 0) begin : g_next_left
      assign w_next = {r_prev_code[WIDTH-2:0], ~r_prev_code[WIDTH-1]};
    end else begin : g_next_right
      assign w_next = {~r_prev_code[0], r_prev_code[WIDTH-1:1]};
    end
  endgenerate

  assign w_in_seq  = (bus.count_in == w_next);
  assign w_run_inc = (r_run == RUN_W'(LOCK_LEN)) ? r_run : r_run + RUN_W'(1);
  assign w_err     = bus.in_valid && (!w_legal || (r_prev_ok && !w_in_seq));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_code <= '0;
      r_prev_ok   <= 1'b0;
      r_run       <= '0;
      r_state     <= ST_UNLOCKED;
      r_idx       <= '0;
      r_onehot    <= '0;
      r_wrap      <= 1'b0;
      r_code_err  <= 1'b0;
      r_seq_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_wrap     <= 1'b0;
      r_code_err <= 1'b0;
      r_seq_err  <= 1'b0;
      if (bus.in_valid) begin
        if (!w_legal) begin
          r_code_err <= 1'b1;
          r_onehot   <= '0;
          r_prev_ok  <= 1'b0;
          r_run      <= '0;
          r_state    <= ST_UNLOCKED;
        end else begin
          r_idx       <= w_idx;
          r_onehot    <= N'(1) << w_idx;
          r_prev_code <= bus.count_in;
          r_prev_ok   <= 1'b1;
          if (r_prev_ok) begin
            if (w_in_seq) begin
              r_run  <= w_run_inc;
              // Index 0 has a single predecessor, so this is the ring wrap.
              r_wrap <= (w_idx == '0);
              if (w_run_inc == RUN_W'(LOCK_LEN)) begin
                r_state <= ST_LOCKED;
              end
            end else begin
              r_seq_err <= 1'b1;
              r_run     <= '0;
              r_state   <= ST_UNLOCKED;
            end
          end
        end
      end
      if (bus.err_clr) begin
        r_err_count <= '0;
      end else if (w_err && (r_err_count != '1)) begin
        r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
    end
  end

  assign bus.phase_idx    = r_idx;
  assign bus.phase_onehot = r_onehot;
  assign bus.wrap_pulse   = r_wrap;
  assign bus.code_err     = r_code_err;
  assign bus.seq_err      = r_seq_err;
  assign bus.locked       = (r_state == ST_LOCKED);
  assign bus.err_count    = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_johnson_phase_decoder.sv
// +----------------------------------------------------------------------+
// | tb_johnson_phase_decoder : directed bench with a ring-table model.   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_johnson_phase_decoder;

  localparam int LOCK = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [3:0] s_code = 4'b0000;
  logic s_valid = 1'b0;
  logic s_clr = 1'b0;
  bit   chk_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  johnson_phase_decoder_if #(.WIDTH(4), .ERR_CNT_W(8)) bus1 ();
  johnson_phase_decoder_if #(.WIDTH(4), .ERR_CNT_W(2)) bus2 ();

  assign bus1.count_in = s_code;
  assign bus1.in_valid = s_valid;
  assign bus1.err_clr  = s_clr;
  assign bus2.count_in = s_code;
  assign bus2.in_valid = s_valid;
  assign bus2.err_clr  = s_clr;

  johnson_phase_decoder #(.WIDTH(4), .SHIFT_LEFT(1), .LOCK_LEN(LOCK), .ERR_CNT_W(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1));
  johnson_phase_decoder #(.WIDTH(4), .SHIFT_LEFT(0), .LOCK_LEN(LOCK), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2));

  always #5 clk = ~clk;

  // Ring position k -> code: k ones filling from the bottom, then zeros
  // filling from the bottom; mirrored for the right-shifting ring.
  function automatic logic [3:0] code_of(int k, int sl);
    logic [3:0] c;
    if (k < 4) c = 4'((1 << k) - 1);
    else       c = 4'hF ^ 4'((1 << (k - 4)) - 1);
    if (sl == 0) c = {c[0], c[1], c[2], c[3]};
    return c;
  endfunction

  function automatic int decode(logic [3:0] c, int sl);
    for (int k = 0; k < 8; k++) begin
      if (code_of(k, sl) == c) return k;
    end
    return -1;
  endfunction

  int m_sl  [2] = '{1, 0};
  int m_max [2] = '{255, 3};
  int m_idx [2], m_oh [2], m_wrap [2], m_cerr [2], m_serr [2];
  int m_lk  [2], m_cnt [2], m_pok [2], m_pidx [2], m_run [2];

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_idx[i] = 0; m_oh[i] = 0; m_wrap[i] = 0; m_cerr[i] = 0; m_serr[i] = 0;
        m_lk[i] = 0; m_cnt[i] = 0; m_pok[i] = 0; m_pidx[i] = 0; m_run[i] = 0;
      end else begin
        int k;
        bit err;
        err = 0;
        m_wrap[i] = 0; m_cerr[i] = 0; m_serr[i] = 0;
        if (s_valid) begin
          k = decode(s_code, m_sl[i]);
          if (k < 0) begin
            m_cerr[i] = 1; m_oh[i] = 0; m_pok[i] = 0; m_run[i] = 0; m_lk[i] = 0; err = 1;
          end else begin
            if (m_pok[i] != 0) begin
              if (k == (m_pidx[i] + 1) % 8) begin
                if (m_run[i] < LOCK) m_run[i]++;
                if (m_run[i] == LOCK) m_lk[i] = 1;
                m_wrap[i] = (m_pidx[i] == 7) ? 1 : 0;
              end else begin
                m_serr[i] = 1; m_run[i] = 0; m_lk[i] = 0; err = 1;
              end
            end
            m_idx[i] = k; m_oh[i] = 1 << k; m_pidx[i] = k; m_pok[i] = 1;
          end
        end
        if (s_clr) m_cnt[i] = 0;
        else if (err && m_cnt[i] < m_max[i]) m_cnt[i]++;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(int i, logic [31:0] idx, logic [31:0] oh, logic [31:0] wr,
                         logic [31:0] ce, logic [31:0] se, logic [31:0] lk, logic [31:0] cnt);
    string p;
    p = (i == 0) ? "dut1" : "dut2";
    chk({p, ".phase_idx"},    idx, m_idx[i]);
    chk({p, ".phase_onehot"}, oh,  m_oh[i]);
    chk({p, ".wrap_pulse"},   wr,  m_wrap[i]);
    chk({p, ".code_err"},     ce,  m_cerr[i]);
    chk({p, ".seq_err"},      se,  m_serr[i]);
    chk({p, ".locked"},       lk,  m_lk[i]);
    chk({p, ".err_count"},    cnt, m_cnt[i]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut(0, 32'(bus1.phase_idx), 32'(bus1.phase_onehot), 32'(bus1.wrap_pulse),
              32'(bus1.code_err), 32'(bus1.seq_err), 32'(bus1.locked), 32'(bus1.err_count));
      cmp_dut(1, 32'(bus2.phase_idx), 32'(bus2.phase_onehot), 32'(bus2.wrap_pulse),
              32'(bus2.code_err), 32'(bus2.seq_err), 32'(bus2.locked), 32'(bus2.err_count));
    end
  end

  task automatic step(logic [3:0] c, logic v, logic clr);
    s_code = c; s_valid = v; s_clr = clr;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rev [9] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                          4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] bad [5] = '{4'b0101, 4'b1010, 4'b0110, 4'b1001, 4'b0100};
  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk("reset.phase_idx", 32'(bus1.phase_idx), 0);
    chk("reset.onehot", 32'(bus1.phase_onehot), 0);
    chk("reset.locked", 32'(bus1.locked), 0);
    chk("reset.err_count", 32'(bus1.err_count), 0);
    chk_en = 1'b1;
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Full revolution
    for (int i = 0; i < 9; i++) begin
      step(rev[i], 1'b1, 1'b0);
      chk("rev.phase_idx", 32'(bus1.phase_idx), i % 8);
      chk("rev.locked", 32'(bus1.locked), (i >= 4) ? 1 : 0);
      chk("rev.wrap", 32'(bus1.wrap_pulse), (i == 8) ? 1 : 0);
      if (i == 1) begin
        chk("rev.dut2_idx", 32'(bus2.phase_idx), 7);
        chk("rev.dut2_seq_err", 32'(bus2.seq_err), 1);
      end
    end
    chk("rev.err_count", 32'(bus1.err_count), 0);

    // Illegal code while locked
    step(4'b0101, 1'b1, 1'b0);
    chk("ill.code_err", 32'(bus1.code_err), 1);
    chk("ill.onehot", 32'(bus1.phase_onehot), 0);
    chk("ill.phase_idx", 32'(bus1.phase_idx), 0);
    chk("ill.locked", 32'(bus1.locked), 0);
    chk("ill.err_count", 32'(bus1.err_count), 1);
    step(4'b0111, 1'b1, 1'b0);
    chk("ill.seq_err_a", 32'(bus1.seq_err), 0);
    chk("ill.idx_a", 32'(bus1.phase_idx), 3);
    step(4'b1111, 1'b1, 1'b0);
    chk("ill.seq_err_b", 32'(bus1.seq_err), 0);
    chk("ill.idx_b", 32'(bus1.phase_idx), 4);

    // Skipped state
    step(4'b0011, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    chk("skip.seq_err", 32'(bus1.seq_err), 1);
    chk("skip.phase_idx", 32'(bus1.phase_idx), 4);
    chk("skip.locked", 32'(bus1.locked), 0);
    chk("skip.err_count", 32'(bus1.err_count), 3);

    // Stall then repeat
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0101, 1'b0, 1'b0);
    step(4'b1110, 1'b0, 1'b0);
    chk("stall.phase_idx", 32'(bus1.phase_idx), 4);
    chk("stall.onehot", 32'(bus1.phase_onehot), 32'h10);
    chk("stall.pulses", {29'd0, bus1.wrap_pulse, bus1.code_err, bus1.seq_err}, 0);
    step(4'b1111, 1'b1, 1'b0);
    chk("repeat.seq_err", 32'(bus1.seq_err), 1);
    chk("repeat.err_count", 32'(bus1.err_count), 4);

    // Saturation and clear
    step(4'b0000, 1'b0, 1'b1);
    chk("clr.err_count1", 32'(bus1.err_count), 0);
    chk("clr.err_count2", 32'(bus2.err_count), 0);
    for (int i = 0; i < 5; i++) begin
      step(bad[i], 1'b1, 1'b0);
      chk("sat.err_count2", 32'(bus2.err_count), sat_exp[i]);
    end
    chk("sat.err_count1", 32'(bus1.err_count), 5);
    step(4'b1011, 1'b1, 1'b1);
    chk("clrerr.code_err", 32'(bus2.code_err), 1);
    chk("clrerr.err_count2", 32'(bus2.err_count), 0);
    chk("clrerr.err_count1", 32'(bus1.err_count), 0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) step(rev[i], 1'b1, 1'b0);
    chk("pre_rst.locked", 32'(bus1.locked), 1);
    step(4'b0101, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("arst.phase_idx", 32'(bus1.phase_idx), 0);
    chk("arst.onehot", 32'(bus1.phase_onehot), 0);
    chk("arst.locked", 32'(bus1.locked), 0);
    chk("arst.dut2_idx", 32'(bus2.phase_idx), 0);
    #1 reset_n = 1'b1;
    step(4'b0011, 1'b1, 1'b0);
    step(4'b0111, 1'b1, 1'b0);
    chk("post_rst.seq_err", 32'(bus1.seq_err), 0);
    chk("post_rst.locked", 32'(bus1.locked), 0);
    chk("post_rst.phase_idx", 32'(bus1.phase_idx), 3);

    step(4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
